// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bundle: raw line inputs and decoded byte/strobe outputs.
// slave = receiver side, master = line driver / consumer side.
interface ps2_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [0:7] scancode;
  logic       trigger;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scancode,
    output trigger,
    output parity_err,
    output frame_err,
    output busy
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scancode,
    input  trigger,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: sync, glitch filter, 11-bit frame FSM.
// Receive-only; reports good bytes, parity errors and framing errors/timeouts.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          reset_n,
  ps2_receiver_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    FL  = 8'(FILTER_LEN);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_d;
  logic [7:0]    flt_q, flt_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          pok_q, pok_d;
  logic [7:0]    code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          trig_q, trig_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  // Two-flop synchronizers for both PS/2 lines, idle-high on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples
  always_comb begin
    clk_f_d = clk_f_q;
    flt_d   = '0;
    if (clk_s2_q != clk_f_q) begin
      if (flt_q == FL - 8'd1) begin
        clk_f_d = clk_s2_q;
      end else begin
        flt_d = flt_q + 8'd1;
      end
    end
  end

  assign fall = clk_f_q & ~clk_f_d;

  // Filter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_f_q <= 1'b1;
      flt_q   <= '0;
    end else begin
      clk_f_q <= clk_f_d;
      flt_q   <= flt_d;
    end
  end

  // Frame FSM next state, shift register, timeout and strobe decisions
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    pok_d   = pok_q;
    code_d  = code_q;
    trig_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = tmo_q + 1'b1;
    if (state_q == IDLE || fall) begin
      tmo_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (fall) begin
          sr_d = {dat_s2_q, sr_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          pok_d   = ^{sr_q, dat_s2_q};
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!pok_q) begin
            perr_d = 1'b1;
          end else if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else begin
            code_d = sr_q;
            trig_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An open frame with no falling edge for too long is abandoned
    if (state_q != IDLE && !fall && tmo_d == TMO) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // Frame FSM registers and registered strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sr_q    <= '0;
      pok_q   <= 1'b0;
      code_q  <= '0;
      tmo_q   <= '0;
      trig_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      pok_q   <= pok_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
      trig_q  <= trig_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.scancode   = code_q;
  assign bus.trigger    = trig_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: scoreboard of expected strobes
// pushed per frame and popped by a monitor when a strobe appears.
module tb_ps2_receiver;

  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  typedef struct {
    int         kind;
    logic [7:0] code;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   err_cyc;
  logic [7:0] held;
  exp_t exp_q[$];

  ps2_receiver_if bus ();

  ps2_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.trigger || bus.parity_err || bus.frame_err) begin
        int   k;
        exp_t e;
        k = bus.trigger ? 0 : (bus.parity_err ? 1 : 2);
        chk("onehot", 32'(bus.trigger) + 32'(bus.parity_err)
            + 32'(bus.frame_err), 1);
        if (bus.frame_err) err_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", k, 99);
        end else begin
          e = exp_q.pop_front();
          chk("kind", k, e.kind);
          chk("scancode", bus.scancode, e.code);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set up, low half, high half with optional glitch
  task automatic send_bit(input logic v, input bit glitch);
    bus.ps2_data = v;
    wait_cyc(HALF / 2);
    bus.ps2_clk = 1'b0;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(10);
      bus.ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      bus.ps2_clk = 1'b1;
      wait_cyc(HALF / 2 - 10 - (FL - 2));
    end else begin
      wait_cyc(HALF / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip,
                            input logic stop, input bit glitch);
    logic par;
    exp_t e;
    par = (~^b) ^ pflip;
    if (pflip) begin
      e.kind = 1;
      e.code = held;
    end else if (!stop) begin
      e.kind = 2;
      e.code = held;
    end else begin
      e.kind = 0;
      e.code = b;
      held   = b;
    end
    exp_q.push_back(e);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    bus.ps2_data = 1'b1;
  endtask

  task automatic settle(input string tag);
    wait_cyc(FL + 10);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    exp_t e;
    int   c0;
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    err_cyc = -1;
    held    = 8'h00;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n = 1'b0;
    wait_cyc(5);
    chk("rst_scancode", bus.scancode, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.trigger, bus.parity_err, bus.frame_err}, 0);
    reset_n = 1'b1;
    wait_cyc(5);

    send_frame(8'h1c, 0, 1'b1, 0);
    settle("f1c");
    chk("f1c_code", bus.scancode, 8'h1c);

    send_frame(8'hf0, 0, 1'b1, 0);
    send_frame(8'h1c, 0, 1'b1, 0);
    settle("b2b");

    send_frame(8'h1c, 1, 1'b1, 0);
    settle("par");
    chk("par_hold", bus.scancode, 8'h1c);

    send_frame(8'h5a, 0, 1'b0, 0);
    settle("stop");
    chk("stop_hold", bus.scancode, 8'h1c);

    // Start + 4 data bits, then silence until timeout
    e.kind = 2;
    e.code = held;
    exp_q.push_back(e);
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    bus.ps2_data = 1'b0;
    wait_cyc(HALF / 2);
    c0 = cyc;
    bus.ps2_clk = 1'b0;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(2);
    chk("tmo_busy_open", bus.busy, 1);
    wait_cyc(TMO + 100);
    chk("tmo_latency", err_cyc - c0, FL + 2 + TMO);
    settle("tmo");
    chk("tmo_hold", bus.scancode, 8'h1c);

    send_frame(8'h29, 0, 1'b1, 1);
    settle("glitch");
    chk("glitch_code", bus.scancode, 8'h29);

    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 0);
    reset_n = 1'b0;
    held    = 8'h00;
    wait_cyc(3);
    chk("abort_scancode", bus.scancode, 8'h00);
    chk("abort_busy", bus.busy, 0);
    reset_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h12, 0, 1'b1, 0);
    settle("post_rst");
    chk("post_rst_code", bus.scancode, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
